// File: rtl/hilo_accum_unit.sv
// HI/LO register pair with mthi/mtlo/mult moves, a two-cycle madd/msub
// accumulator, and registered mfhi/mflo readback.
module hilo_accum_unit (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Valid,
   input  logic [3:0]  Op,
   input  logic [63:0] Product,
   output logic        Ready,
   output logic        Busy,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic [31:0] ReadData,
   output logic        ReadValid,
   output logic        dbg_state
);

   localparam logic [3:0] OP_MTHI = 4'd1;
   localparam logic [3:0] OP_MTLO = 4'd2;
   localparam logic [3:0] OP_MULT = 4'd3;
   localparam logic [3:0] OP_MADD = 4'd4;
   localparam logic [3:0] OP_MSUB = 4'd5;
   localparam logic [3:0] OP_MFHI = 4'd6;
   localparam logic [3:0] OP_MFLO = 4'd7;

   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   // Handshake: a request transfers on a rising Clk edge where Valid && Ready.
   // Ready is low only during the single ACC cycle; upstream must hold the
   // request (Valid, Op, Product stable) until that edge.
   state_t      state, next_state;
   logic        accept;
   logic        is_acc_op;
   logic        acc_sub;
   logic [63:0] pending;
   logic [63:0] hilo;
   logic [63:0] acc_result;

   assign hilo       = {Hi, Lo};
   assign accept     = Valid && (state == IDLE);
   assign is_acc_op  = (Op == OP_MADD) || (Op == OP_MSUB);
   assign acc_result = acc_sub ? (hilo - pending) : (hilo + pending);

   assign Ready     = (state == IDLE);
   assign Busy      = ~Ready;
   assign dbg_state = state;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept && is_acc_op) next_state = ACC;
         ACC:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Hi        <= 32'd0;
         Lo        <= 32'd0;
         ReadData  <= 32'd0;
         ReadValid <= 1'b0;
         pending   <= 64'd0;
         acc_sub   <= 1'b0;
      end else begin
         ReadValid <= 1'b0;
         if (state == ACC) begin
            {Hi, Lo} <= acc_result;
         end else if (accept) begin
            case (Op)
               OP_MTHI: Hi <= Product[31:0];
               OP_MTLO: Lo <= Product[31:0];
               OP_MULT: {Hi, Lo} <= Product;
               OP_MADD, OP_MSUB: begin
                  pending <= Product;
                  acc_sub <= (Op == OP_MSUB);
               end
               OP_MFHI: begin
                  ReadData  <= Hi;
                  ReadValid <= 1'b1;
               end
               OP_MFLO: begin
                  ReadData  <= Lo;
                  ReadValid <= 1'b1;
               end
               default: ;  // opcodes 0 and 8-15 are accepted with no effect
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hilo_accum_unit.sv
// Directed bench for hilo_accum_unit: hand-computed vectors per scenario.
module tb_hilo_accum_unit;

   logic        Clk;
   logic        Rst_n;
   logic        Valid;
   logic [3:0]  Op;
   logic [63:0] Product;
   logic        Ready;
   logic        Busy;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic [31:0] ReadData;
   logic        ReadValid;
   logic        dbg_state;

   int tests_run;
   int tests_failed;

   hilo_accum_unit dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Valid     (Valid),
      .Op        (Op),
      .Product   (Product),
      .Ready     (Ready),
      .Busy      (Busy),
      .Hi        (Hi),
      .Lo        (Lo),
      .ReadData  (ReadData),
      .ReadValid (ReadValid),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // driver tasks: inputs change 1 time unit after a rising edge
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [63:0] prod);
      Valid   = 1'b1;
      Op      = op;
      Product = prod;
      step();
      Valid   = 1'b0;
      Op      = 4'd0;
      Product = 64'd0;
   endtask

   task automatic test_reset();
      Valid   = 1'b0;
      Op      = 4'd0;
      Product = 64'd0;
      Rst_n   = 1'b0;
      step();
      step();
      tests_run += 7;
      if (Hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi got %h want 0", Hi); end
      if (Lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo got %h want 0", Lo); end
      if (ReadData !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0", ReadData); end
      if (ReadValid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid got %b want 0", ReadValid); end
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", Ready); end
      if (Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", Busy); end
      if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL reset_state got %b want 0", dbg_state); end
      Rst_n = 1'b1;
      step();
   endtask

   task automatic test_mult();
      issue(4'd3, 64'h00000001_FFFFFFFF);
      tests_run += 4;
      if (Hi !== 32'h00000001) begin tests_failed++; $display("FAIL mult_hi got %h want 00000001", Hi); end
      if (Lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mult_lo got %h want ffffffff", Lo); end
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL mult_ready got %b want 1", Ready); end
      if (ReadValid !== 1'b0) begin tests_failed++; $display("FAIL mult_rvalid got %b want 0", ReadValid); end
   endtask

   task automatic test_madd();
      issue(4'd4, 64'h00000000_00000001);
      tests_run += 4;
      if (Ready !== 1'b0) begin tests_failed++; $display("FAIL madd_acc_ready got %b want 0", Ready); end
      if (Busy !== 1'b1) begin tests_failed++; $display("FAIL madd_acc_busy got %b want 1", Busy); end
      if (Hi !== 32'h00000001) begin tests_failed++; $display("FAIL madd_acc_hi got %h want 00000001", Hi); end
      if (Lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL madd_acc_lo got %h want ffffffff", Lo); end
      step();
      tests_run += 4;
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL madd_ready got %b want 1", Ready); end
      if (Busy !== 1'b0) begin tests_failed++; $display("FAIL madd_busy got %b want 0", Busy); end
      if (Hi !== 32'h00000002) begin tests_failed++; $display("FAIL madd_hi got %h want 00000002", Hi); end
      if (Lo !== 32'h00000000) begin tests_failed++; $display("FAIL madd_lo got %h want 00000000", Lo); end
   endtask

   task automatic test_msub_wrap();
      issue(4'd3, 64'd0);
      issue(4'd5, 64'd1);
      tests_run += 2;
      if (Hi !== 32'd0) begin tests_failed++; $display("FAIL msub_acc_hi got %h want 0", Hi); end
      if (Ready !== 1'b0) begin tests_failed++; $display("FAIL msub_acc_ready got %b want 0", Ready); end
      step();
      tests_run += 3;
      if (Hi !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL msub_hi got %h want ffffffff", Hi); end
      if (Lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL msub_lo got %h want ffffffff", Lo); end
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL msub_ready got %b want 1", Ready); end
   endtask

   task automatic test_move_read();
      // Lo is ffffffff from the msub wrap
      issue(4'd1, 64'hDEADBEEF_12345678);
      tests_run += 2;
      if (Hi !== 32'h12345678) begin tests_failed++; $display("FAIL mthi_hi got %h want 12345678", Hi); end
      if (Lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mthi_lo got %h want ffffffff", Lo); end
      Valid = 1'b1;
      Op    = 4'd7;
      step();
      tests_run += 2;
      if (ReadValid !== 1'b1) begin tests_failed++; $display("FAIL mflo_rvalid got %b want 1", ReadValid); end
      if (ReadData !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mflo_rdata got %h want ffffffff", ReadData); end
      Op = 4'd6;
      step();
      Valid = 1'b0;
      Op    = 4'd0;
      tests_run += 2;
      if (ReadValid !== 1'b1) begin tests_failed++; $display("FAIL mfhi_rvalid got %b want 1", ReadValid); end
      if (ReadData !== 32'h12345678) begin tests_failed++; $display("FAIL mfhi_rdata got %h want 12345678", ReadData); end
      step();
      tests_run += 2;
      if (ReadValid !== 1'b0) begin tests_failed++; $display("FAIL read_idle_rvalid got %b want 0", ReadValid); end
      if (ReadData !== 32'h12345678) begin tests_failed++; $display("FAIL read_hold_rdata got %h want 12345678", ReadData); end
      issue(4'd2, 64'hAAAA5555_000000C3);
      tests_run += 2;
      if (Lo !== 32'h000000C3) begin tests_failed++; $display("FAIL mtlo_lo got %h want 000000c3", Lo); end
      if (Hi !== 32'h12345678) begin tests_failed++; $display("FAIL mtlo_hi got %h want 12345678", Hi); end
   endtask

   task automatic test_noop();
      issue(4'd0, 64'hFFFFFFFF_FFFFFFFF);
      issue(4'd9, 64'h11111111_22222222);
      issue(4'd15, 64'h33333333_44444444);
      tests_run += 4;
      if (Hi !== 32'h12345678) begin tests_failed++; $display("FAIL noop_hi got %h want 12345678", Hi); end
      if (Lo !== 32'h000000C3) begin tests_failed++; $display("FAIL noop_lo got %h want 000000c3", Lo); end
      if (ReadValid !== 1'b0) begin tests_failed++; $display("FAIL noop_rvalid got %b want 0", ReadValid); end
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL noop_ready got %b want 1", Ready); end
   endtask

   task automatic test_held_read();
      issue(4'd3, 64'h00000005_80000000);
      issue(4'd4, 64'h00000000_80000000);
      // mfhi presented during ACC and held until accepted
      Valid = 1'b1;
      Op    = 4'd6;
      tests_run += 1;
      if (Ready !== 1'b0) begin tests_failed++; $display("FAIL held_acc_ready got %b want 0", Ready); end
      step();
      tests_run += 3;
      if (ReadValid !== 1'b0) begin tests_failed++; $display("FAIL held_early_rvalid got %b want 0", ReadValid); end
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL held_ready got %b want 1", Ready); end
      if (Hi !== 32'h00000006) begin tests_failed++; $display("FAIL held_hi got %h want 00000006", Hi); end
      step();
      Valid = 1'b0;
      Op    = 4'd0;
      tests_run += 2;
      if (ReadValid !== 1'b1) begin tests_failed++; $display("FAIL held_rvalid got %b want 1", ReadValid); end
      if (ReadData !== 32'h00000006) begin tests_failed++; $display("FAIL held_rdata got %h want 00000006", ReadData); end
   endtask

   task automatic test_reset_during_acc();
      issue(4'd4, 64'h00000001_00000001);
      #2;
      Rst_n = 1'b0;
      #1;
      tests_run += 6;
      if (Hi !== 32'd0) begin tests_failed++; $display("FAIL racc_hi got %h want 0", Hi); end
      if (Lo !== 32'd0) begin tests_failed++; $display("FAIL racc_lo got %h want 0", Lo); end
      if (ReadData !== 32'd0) begin tests_failed++; $display("FAIL racc_rdata got %h want 0", ReadData); end
      if (ReadValid !== 1'b0) begin tests_failed++; $display("FAIL racc_rvalid got %b want 0", ReadValid); end
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL racc_ready got %b want 1", Ready); end
      if (Busy !== 1'b0) begin tests_failed++; $display("FAIL racc_busy got %b want 0", Busy); end
      step();
      #2;
      Rst_n = 1'b1;
      Valid = 1'b1;
      Op    = 4'd2;
      Product = 64'h00000000_00000007;
      step();
      Valid = 1'b0;
      Op    = 4'd0;
      tests_run += 3;
      if (Lo !== 32'h00000007) begin tests_failed++; $display("FAIL post_reset_lo got %h want 00000007", Lo); end
      if (Hi !== 32'd0) begin tests_failed++; $display("FAIL post_reset_hi got %h want 0", Hi); end
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready got %b want 1", Ready); end
   endtask

   task automatic test_back_to_back();
      Valid   = 1'b1;
      Op      = 4'd1;
      Product = 64'h0000_0000_CAFE0001;
      step();
      tests_run += 1;
      if (Hi !== 32'hCAFE0001) begin tests_failed++; $display("FAIL b2b_mthi got %h want cafe0001", Hi); end
      Op      = 4'd2;
      Product = 64'h0000_0000_BEEF0002;
      step();
      tests_run += 1;
      if (Lo !== 32'hBEEF0002) begin tests_failed++; $display("FAIL b2b_mtlo got %h want beef0002", Lo); end
      Op      = 4'd5;
      Product = 64'h00000000_BEEF0003;
      step();
      tests_run += 1;
      if (Busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy got %b want 1", Busy); end
      Op = 4'd7;
      step();
      tests_run += 2;
      if (Hi !== 32'hCAFE0000) begin tests_failed++; $display("FAIL b2b_msub_hi got %h want cafe0000", Hi); end
      if (Lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL b2b_msub_lo got %h want ffffffff", Lo); end
      step();
      Valid = 1'b0;
      Op    = 4'd0;
      tests_run += 2;
      if (ReadValid !== 1'b1) begin tests_failed++; $display("FAIL b2b_rvalid got %b want 1", ReadValid); end
      if (ReadData !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL b2b_rdata got %h want ffffffff", ReadData); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      Rst_n        = 1'b1;
      Valid        = 1'b0;
      Op           = 4'd0;
      Product      = 64'd0;
      #1;
      test_reset();
      test_mult();
      test_madd();
      test_msub_wrap();
      test_move_read();
      test_noop();
      test_held_read();
      test_reset_during_acc();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
